// File: rtl/card_pkg.sv
// card_pkg: shared geometry, pixel type and draw states for the card blitter.
package card_pkg;
    localparam int CARD_W      = 16;
    localparam int CARD_H      = 32;
    localparam int SCREEN_W    = 256;
    localparam int SCREEN_H    = 240;
    localparam int CARD_PIXELS = CARD_W * CARD_H;
    typedef logic [2:0] pix_t;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} blit_state_t;
endpackage

// File: rtl/card_blitter_if.sv
// card_blitter_if: control request, card-memory read port and frame-buffer write port.
interface card_blitter_if;
    import card_pkg::*;
    logic        start;
    logic [7:0]  dst_x;
    logic [7:0]  dst_y;
    logic        trans_en;
    pix_t        trans_color;
    logic        busy;
    logic        done;
    logic        card_re;
    logic [8:0]  card_addr;
    pix_t        card_data;
    logic        fb_we;
    logic [15:0] fb_addr;
    pix_t        fb_data;
    modport master (
        output start, dst_x, dst_y, trans_en, trans_color, card_data,
        input  busy, done, card_re, card_addr, fb_we, fb_addr, fb_data
    );
    modport slave (
        input  start, dst_x, dst_y, trans_en, trans_color, card_data,
        output busy, done, card_re, card_addr, fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/card_scan_ctr.sv
// card_scan_ctr: row-major pixel counter over the card, split into column and row.
module card_scan_ctr
    import card_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] col,
    output logic [4:0] row,
    output logic       last
);
    logic [8:0] cnt;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= cnt + 9'd1;
    assign {row, col} = cnt;
    assign last = cnt == 9'(CARD_PIXELS - 1);
endmodule

// File: rtl/card_blitter.sv
// card_blitter: copies a 16x32 card sprite into the 256x240 frame buffer
// with clipping at the screen edges and optional colour-key transparency.
module card_blitter
    import card_pkg::*;
(
    input  logic    clock,
    input  logic    reset_n,
    card_blitter_if.slave bus
);
    blit_state_t state, next;
    logic [3:0]  col;
    logic [4:0]  row;
    logic        last;
    logic        accept;
    logic [7:0]  x_l, y_l;
    logic        te_l;
    pix_t        tc_l;
    logic [8:0]  sx, sy;
    logic        valid, clip_q, done_q;
    logic [7:0]  sx_q, sy_q;
    assign accept = state == IDLE && bus.start;
    card_scan_ctr u_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (accept),
        .enable  (state == READ && !last),
        .col     (col),
        .row     (row),
        .last    (last)
    );
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        next = state == IDLE ? (bus.start ? READ : IDLE) :
               state == READ ? (last ? DRAIN : READ) : IDLE;
    end
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            x_l  <= '0;
            y_l  <= '0;
            te_l <= 1'b0;
            tc_l <= '0;
        end else if (accept) begin
            x_l  <= bus.dst_x;
            y_l  <= bus.dst_y;
            te_l <= bus.trans_en;
            tc_l <= bus.trans_color;
        end
    // Nine-bit sums so that off-screen pixels are clipped rather than wrapped.
    assign sx = {1'b0, x_l} + 9'(col);
    assign sy = {1'b0, y_l} + 9'(row);
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            valid  <= 1'b0;
            clip_q <= 1'b0;
            sx_q   <= '0;
            sy_q   <= '0;
            done_q <= 1'b0;
        end else begin
            valid  <= state == READ;
            clip_q <= sx >= 9'(SCREEN_W) || sy >= 9'(SCREEN_H);
            sx_q   <= sx[7:0];
            sy_q   <= sy[7:0];
            done_q <= state == DRAIN;
        end
    assign bus.busy      = state != IDLE;
    assign bus.done      = done_q;
    assign bus.card_re   = state == READ;
    assign bus.card_addr = {row, col};
    assign bus.fb_addr   = {sy_q, sx_q};
    assign bus.fb_data   = bus.card_data;
    assign bus.fb_we     = valid && !clip_q && !(te_l && bus.card_data == tc_l);
endmodule

// File: tb/tb_card_blitter.sv
// tb_card_blitter: randomized draws checked every cycle against a cycle-count
// reference of the blit, plus literal expectations for the directed scenarios.
module tb_card_blitter;
    import card_pkg::*;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;
    card_blitter_if bus();
    card_blitter dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    pix_t mem [512];
    int checks = 0, errors = 0;
    int cyc = 0;
    logic [7:0] mx, my;
    logic mte;
    pix_t mtc;
    int wr_cnt = 0, done_cnt = 0;
    logic [15:0] last_fb_addr;
    pix_t last_fb_data;
    always @(posedge clock)
        if (bus.card_re) bus.card_data <= mem[bus.card_addr];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask
    // Reference: a draw is just "cycles elapsed since the accepted start".
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc = 0;
        else if ((cyc == 0 || cyc >= 514) && bus.start) begin
            cyc = 1;
            mx = bus.dst_x;
            my = bus.dst_y;
            mte = bus.trans_en;
            mtc = bus.trans_color;
        end else if (cyc != 0) cyc = cyc >= 514 ? 0 : cyc + 1;
    end
    int k, sx, sy;
    logic exp_we;
    always @(negedge clock) begin
        k = cyc - 2;
        exp_we = 1'b0;
        if (cyc >= 2 && cyc <= 513) begin
            sx = int'(mx) + k % 16;
            sy = int'(my) + k / 16;
            exp_we = sx < 256 && sy < 240 && !(mte && mem[k] == mtc);
        end
        chk("busy", bus.busy, 32'(cyc >= 1 && cyc <= 513));
        chk("done", bus.done, 32'(cyc == 514));
        chk("card_re", bus.card_re, 32'(cyc >= 1 && cyc <= 512));
        chk("fb_we", bus.fb_we, 32'(exp_we));
        if (cyc >= 1 && cyc <= 512) chk("card_addr", bus.card_addr, 32'(cyc - 1));
        if (exp_we) begin
            chk("fb_addr", bus.fb_addr, {16'd0, sy[7:0], sx[7:0]});
            chk("fb_data", bus.fb_data, 32'(mem[k]));
        end
        if (!reset_n) begin
            chk("rst_card_addr", bus.card_addr, 0);
            chk("rst_fb_addr", bus.fb_addr, 0);
        end
        if (bus.fb_we === 1'b1) begin
            wr_cnt++;
            last_fb_addr = bus.fb_addr;
            last_fb_data = bus.fb_data;
        end
        if (bus.done === 1'b1) done_cnt++;
    end
    // Called at a negedge with the blitter idle; returns at the done cycle.
    task automatic run_draw(input logic [7:0] x, input logic [7:0] y, input logic te,
                            input pix_t tc, output int writes, output int done_at);
        bus.dst_x = x;
        bus.dst_y = y;
        bus.trans_en = te;
        bus.trans_color = tc;
        bus.start = 1'b1;
        wr_cnt = 0;
        @(negedge clock);
        bus.start = 1'b0;
        done_at = -1;
        for (int n = 1; n <= 600 && done_at < 0; n++) begin
            if (bus.done === 1'b1) done_at = n;
            else @(negedge clock);
        end
        writes = wr_cnt;
    endtask
    task automatic wait_done(input int from, output int at);
        at = from;
        while (bus.done !== 1'b1 && at < 700) begin
            @(negedge clock);
            at++;
        end
    endtask
    int writes, done_at, n;
    initial begin
        bus.start = 1'b0;
        bus.dst_x = '0;
        bus.dst_y = '0;
        bus.trans_en = 1'b0;
        bus.trans_color = '0;
        for (int i = 0; i < 512; i++) mem[i] = pix_t'(i);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_fb_we", bus.fb_we, 0);
        chk("reset_card_re", bus.card_re, 0);
        @(negedge clock);
        run_draw(8'd0, 8'd0, 1'b0, 3'd0, writes, done_at);
        chk("t1_writes", writes, 512);
        chk("t1_done_at", done_at, 514);
        chk("t1_last_addr", last_fb_addr, 16'h1f0f);
        chk("t1_last_data", last_fb_data, 3'd7);
        run_draw(8'd248, 8'd224, 1'b0, 3'd0, writes, done_at);
        chk("t2_writes", writes, 128);
        chk("t2_done_at", done_at, 514);
        chk("t2_last_addr", last_fb_addr, {8'd239, 8'd255});
        for (int i = 0; i < 512; i++) mem[i] = 3'b101;
        mem[0] = 3'b010;
        run_draw(8'd100, 8'd50, 1'b1, 3'b101, writes, done_at);
        chk("t3_writes", writes, 1);
        chk("t3_done_at", done_at, 514);
        chk("t3_addr", last_fb_addr, {8'd50, 8'd100});
        chk("t3_data", last_fb_data, 3'b010);
        for (int i = 0; i < 512; i++) mem[i] = pix_t'($urandom_range(0, 7));
        @(negedge clock);
        done_cnt = 0;
        bus.dst_x = 8'd40;
        bus.dst_y = 8'd60;
        bus.trans_en = 1'b0;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (98) @(negedge clock);
        bus.start = 1'b1;
        bus.dst_x = 8'd200;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done(100, n);
        chk("t4_done_at", n, 514);
        bus.start = 1'b1;
        bus.dst_x = 8'd16;
        @(negedge clock);
        bus.start = 1'b0;
        chk("t4_restart_busy", bus.busy, 1);
        chk("t4_done_count", done_cnt, 1);
        wait_done(1, n);
        chk("t4_restart_done_at", n, 514);
        @(negedge clock);
        chk("t4_done_count2", done_cnt, 2);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (299) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_busy", bus.busy, 0);
        chk("t5_fb_we", bus.fb_we, 0);
        chk("t5_card_re", bus.card_re, 0);
        chk("t5_done", bus.done, 0);
        chk("t5_fb_addr", bus.fb_addr, 0);
        done_cnt = 0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        chk("t5_no_done", done_cnt, 0);
        run_draw(8'd7, 8'd9, 1'b0, 3'd0, writes, done_at);
        chk("t5_done_at", done_at, 514);
        chk("t5_writes", writes, 512);
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 512; i++) mem[i] = pix_t'($urandom_range(0, 7));
            run_draw(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), pix_t'($urandom_range(0, 7)), writes, done_at);
            chk("rand_done_at", done_at, 514);
        end
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/card_blitter.md
Name: card_blitter

Overview:
- Reader-side engine for the 512x3 card sprite memory (16 wide x 32 tall, row-major, 3-bit colour).
- On a start request it scans the card memory's read port (rAddr/RE/dataOut, 1-cycle registered read latency).
- It copies each pixel into the 256x240 frame-buffer write port at a requested screen position, with clipping and optional transparency.
- It sits between the game/control FSM, the card memories and the frame-buffer RAM feeding the VGA scan-out.

Parameters:
- CARD_W, 16, card width in pixels.
- CARD_H, 32, card height in pixels; CARD_W*CARD_H must equal 512.
- SCREEN_W, 256, frame-buffer width; fb_addr = y*SCREEN_W + x.
- SCREEN_H, 240, frame-buffer height.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  draw request, sampled only in IDLE.
- dst_x  in  8  screen x of card top-left.
- dst_y  in  8  screen y of card top-left.
- trans_en  in  1  enable transparency, latched at start.
- trans_color  in  3  colour treated as transparent, latched at start.
- busy  out  1  high while a draw is in progress.
- done  out  1  one-cycle pulse after the last write.
- card_re  out  1  card memory read enable.
- card_addr  out  9  card memory read address.
- card_data  in  3  card memory dataOut, valid the cycle after address.
- fb_we  out  1  frame-buffer write enable.
- fb_addr  out  16  frame-buffer write address, {y[7:0], x[7:0]}.
- fb_data  out  3  frame-buffer write data.

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy, done, card_re, fb_we = 0; card_addr, fb_addr = 0; pipeline valid cleared. No done pulse follows a reset that interrupts a draw.
- States:
  - IDLE: start=1 at edge E0 latches dst_x, dst_y, trans_en, trans_color; pixel counter cleared; go to READ.
  - READ: issue k = 0..511 over 512 cycles.
  - DRAIN: one cycle; go to IDLE.
- Cycle numbering: cycle 1 = the cycle after E0.
- Read phase: in cycle k+1, card_re=1 and card_addr=k; col = k mod 16, row = k/16.
- Write stage: a one-stage pipeline register holds valid, screen x and screen y for the address issued in the previous cycle.
  - In cycle k+2, fb_addr = {y, x} of pixel k, and fb_data = card_data (combinational pass-through).
  - fb_we = valid AND NOT clipped AND NOT (trans_en_l AND card_data == trans_color_l).
- Clipping: sx = dst_x + col and sy = dst_y + row are computed 9 bits wide. Clipped = sx >= 256 or sy >= 240. Clipped pixels are never written; there is no wrap-around.
- Timing:
  - Last write (pixel 511) occurs in cycle 513 (DRAIN).
  - done=1 in cycle 514 only, with state IDLE.
  - busy=1 in cycles 1..513, busy=0 from cycle 514.
  - Start-to-done latency is 514 cycles.
- card_re=0 and card_addr holds its last value outside READ; fb_we=0 outside cycles 2..513.
- Start while busy is ignored (no queueing). Start in the done cycle is accepted normally.
- dst/trans inputs changing while busy have no effect.

Decomposition:
- Package card_pkg:
  - CARD_W, CARD_H, SCREEN_W, SCREEN_H, CARD_PIXELS=512.
  - Typedef pix_t (logic [2:0]).
  - State enum blit_state_t {IDLE, READ, DRAIN}.
- Sub-module card_scan_ctr:
  - 9-bit pixel counter producing col[3:0], row[4:0], last.
  - Inputs clear/enable; reset_n async.
- Top-level contents: FSM, write pipeline register, clip/transparency logic.

Test Plan:
1. Reset, card RAM preloaded with pattern addr[2:0], start with dst=(0,0), trans_en=0.
   - Expect 512 writes, fb_addr = {row, col} with data = k[2:0].
   - First write in cycle 2, done in cycle 514, busy high cycles 1..513.
2. dst=(248,224), trans_en=0.
   - Only pixels with col<8 and row<16 written (128 writes).
   - No fb_addr with x<248 or y<224, i.e. no wrap.
3. RAM all 3'b101 except addr 0 = 3'b010, trans_en=1, trans_color=3'b101.
   - Exactly one write (fb_addr={dst_y, dst_x}, data 3'b010); done still in cycle 514.
4. Second start at cycle 100, and dst_x changed mid-draw.
   - Ignored: only one done pulse, all addresses from the original dst.
   - A start asserted in the done cycle begins a new draw (busy=1 next cycle).
5. reset_n pulled low at cycle 300.
   - Outputs are 0 immediately (asynchronous) and no done pulse follows.
   - After release, a new start completes a full 514-cycle draw.
